// File: rtl/ste_sample_pacer.sv
// Purpose     : buffers upstream samples and releases one per programmable tick to the STE averager.
// Latency     : first dout_update_o arrives max(rate_div_i,1) cycles after the avg_clr_o pulse; push-to-pop >= 1 cycle.
// Backpressure: s_ready_o = !full; a pop frees a slot only for the following cycle. The downstream side has no backpressure.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data_i/s_valid_i upstream sample and valid; s_ready_o is high while the FIFO is not full
//   enable_i           run request (level); every rising run start passes through a one-cycle CLEAR
//   rate_div_i         tick period in clk cycles (0 behaves as 1), sampled only on counter load/reload
//   flush_i            empties the FIFO at this edge; the same-cycle push is dropped and a same-cycle tick underruns
//   dout_o/dout_update_o  sample and one-cycle strobe to the averager (din_i/din_update_i)
//   avg_clr_o          one-cycle clear to the averager (avg_clr_i)
//   fill_o             FIFO occupancy
//   underrun_o         one-cycle pulse when a tick found no sample
//
// Build option: define STE_PACER_HOLD_LAST_EN so that an underrun tick re-emits the last dout_o
// with dout_update_o=1 (zero-order hold). underrun_o still pulses in that case.

module ste_sample_pacer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     enable_i,
  input  logic [DIV_W-1:0]         rate_div_i,
  input  logic                     flush_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic                     dout_update_o,
  output logic                     avg_clr_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     underrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pacing FSM and tick counter
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  reload_val;
  logic              tick;

  // A period of 0 is treated as 1, so both map to a reload value of 0 (tick every cycle).
  assign reload_val = (rate_div_i == '0) ? '0 : (rate_div_i - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = reload_val;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Dropping enable wins over a pending tick: the leaving cycle is silent.
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = reload_val;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO (circular buffer, no bypass)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]     fill_q;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              starve;

  assign fifo_empty = (fill_q == '0);
  assign s_ready_o  = (fill_q < FW'(DEPTH));
  assign fill_o     = fill_q;

  // Flush takes priority: it drops the push and makes any tick in that cycle see an empty FIFO.
  assign push   = s_valid_i && s_ready_o && !flush_i;
  assign pop    = tick && !fifo_empty && !flush_i;
  assign starve = tick && (fifo_empty || flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data_i;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs toward the averager
  // ---------------------------------------------------------------------------
  logic update_d;

`ifdef STE_PACER_HOLD_LAST_EN
  // Every tick strobes; on a starved tick dout_o is unchanged, so the last sample is repeated.
  assign update_d = tick;
`else
  assign update_d = pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_o        <= '0;
      dout_update_o <= 1'b0;
      underrun_o    <= 1'b0;
      avg_clr_o     <= 1'b0;
    end else begin
      if (pop) dout_o <= mem[rd_ptr_q];
      dout_update_o <= update_d;
      underrun_o    <= starve;
      avg_clr_o     <= (state_q == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_ste_sample_pacer.sv
// Purpose     : directed self-checking bench for ste_sample_pacer.
// Latency     : inputs change on the falling edge and outputs are sampled on the falling edge, half a cycle after each rising edge.
// Backpressure: the bench pushes only when it expects s_ready_o=1. The full case is driven explicitly.

module tb_ste_sample_pacer;

`ifdef STE_PACER_HOLD_LAST_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        enable_i;
  logic [15:0] rate_div_i;
  logic        flush_i;
  logic [15:0] dout_o;
  logic        dout_update_o;
  logic        avg_clr_o;
  logic [3:0]  fill_o;
  logic        underrun_o;

  int n_checks = 0;
  int n_errors = 0;

  ste_sample_pacer #(.DATA_W(16), .DEPTH(8), .DIV_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .enable_i      (enable_i),
    .rate_div_i    (rate_div_i),
    .flush_i       (flush_i),
    .dout_o        (dout_o),
    .dout_update_o (dout_update_o),
    .avg_clr_o     (avg_clr_o),
    .fill_o        (fill_o),
    .underrun_o    (underrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] d);
    s_valid_i = 1'b1;
    s_data_i  = d;
    step();
    s_valid_i = 1'b0;
  endtask

  // Advance n cycles and require that no strobe and no underrun appeared.
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen = seen | dout_update_o | underrun_o;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic expect_strobe(input string tag, input logic [15:0] val);
    check({tag, "_upd"}, 32'(dout_update_o), 32'd1);
    check({tag, "_und"}, 32'(underrun_o), 32'd0);
    check({tag, "_dout"}, 32'(dout_o), 32'(val));
  endtask

  task automatic expect_underrun(input string tag, input logic [15:0] last);
    check({tag, "_und"}, 32'(underrun_o), 32'd1);
    check({tag, "_upd"}, 32'(dout_update_o), 32'(HOLD));
    check({tag, "_dout"}, 32'(dout_o), 32'(last));
  endtask

  initial begin
    logic seen;
    rst_n      = 1'b0;
    s_data_i   = '0;
    s_valid_i  = 1'b0;
    enable_i   = 1'b0;
    rate_div_i = '0;
    flush_i    = 1'b0;

    // ---- reset values
    @(negedge clk);
    check("rst_dout",  32'(dout_o), 32'd0);
    check("rst_upd",   32'(dout_update_o), 32'd0);
    check("rst_clr",   32'(avg_clr_o), 32'd0);
    check("rst_und",   32'(underrun_o), 32'd0);
    check("rst_fill",  32'(fill_o), 32'd0);
    check("rst_ready", 32'(s_ready_o), 32'd1);
    rst_n = 1'b1;
    step();

    // ---- T1: 3,5,7 at rate 4, then underrun
    push_word(16'd3);
    push_word(16'd5);
    push_word(16'd7);
    check("t1_fill", 32'(fill_o), 32'd3);
    rate_div_i = 16'd4;
    enable_i   = 1'b1;
    step();
    check("t1_clr_in_clear", 32'(avg_clr_o), 32'd0);
    step();
    check("t1_clr_pulse", 32'(avg_clr_o), 32'd1);
    check("t1_no_early_upd", 32'(dout_update_o), 32'd0);
    quiet("t1_gap0", 3);
    step();
    expect_strobe("t1_s0", 16'd3);
    check("t1_clr_single", 32'(avg_clr_o), 32'd0);
    quiet("t1_gap1", 3);
    step();
    expect_strobe("t1_s1", 16'd5);
    quiet("t1_gap2", 3);
    step();
    expect_strobe("t1_s2", 16'd7);
    quiet("t1_gap3", 3);
    step();
    expect_underrun("t1_under", 16'd7);
    enable_i = 1'b0;
    step();

    // ---- T2: 8 samples at rate 0 -> back-to-back strobes
    for (int i = 0; i < 8; i++) push_word(16'h10 + 16'(i));
    check("t2_fill_full", 32'(fill_o), 32'd8);
    check("t2_ready_low", 32'(s_ready_o), 32'd0);
    rate_div_i = 16'd0;
    enable_i   = 1'b1;
    step();
    step();
    check("t2_clr_pulse", 32'(avg_clr_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      expect_strobe($sformatf("t2_s%0d", i), 16'h10 + 16'(i));
    end
    step();
    expect_underrun("t2_under", 16'h17);
    enable_i = 1'b0;
    step();
    check("t2_idle_upd", 32'(dout_update_o), 32'd0);
    check("t2_idle_und", 32'(underrun_o), 32'd0);

    // ---- T3: 9th sample held upstream while full, accepted after first pop
    for (int i = 0; i < 8; i++) push_word(16'h20 + 16'(i));
    s_valid_i = 1'b1;
    s_data_i  = 16'h28;
    step();
    check("t3_ready_full", 32'(s_ready_o), 32'd0);
    check("t3_fill_full", 32'(fill_o), 32'd8);
    rate_div_i = 16'd2;
    enable_i   = 1'b1;
    step();
    step();
    check("t3_clr_pulse", 32'(avg_clr_o), 32'd1);
    step();
    step();
    expect_strobe("t3_s0", 16'h20);
    check("t3_fill_after_pop", 32'(fill_o), 32'd7);
    check("t3_ready_after_pop", 32'(s_ready_o), 32'd1);
    step();
    check("t3_ninth_accepted", 32'(fill_o), 32'd8);
    s_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_strobe($sformatf("t3_s%0d", k), 16'h20 + 16'(k));
      quiet($sformatf("t3_gap%0d", k), 1);
    end
    step();
    expect_underrun("t3_under", 16'h28);
    enable_i = 1'b0;
    step();

    // ---- T4: flush with fill 5 and a same-cycle push; flush on a tick
    for (int i = 0; i < 5; i++) push_word(16'h30 + 16'(i));
    check("t4_fill5", 32'(fill_o), 32'd5);
    flush_i   = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 16'h99;
    step();
    check("t4_fill_flushed", 32'(fill_o), 32'd0);
    check("t4_ready_flushed", 32'(s_ready_o), 32'd1);
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    step();
    check("t4_push_dropped", 32'(fill_o), 32'd0);
    rate_div_i = 16'd3;
    enable_i   = 1'b1;
    step();
    step();
    check("t4_clr_pulse", 32'(avg_clr_o), 32'd1);
    quiet("t4_gap0", 2);
    step();
    expect_underrun("t4_under", 16'h28);
    s_valid_i = 1'b1;
    s_data_i  = 16'h40;
    step();
    s_valid_i = 1'b0;
    check("t4_fill_one", 32'(fill_o), 32'd1);
    step();
    flush_i = 1'b1;
    step();
    expect_underrun("t4_flush_tick", 16'h28);
    check("t4_fill_tick_flush", 32'(fill_o), 32'd0);
    flush_i  = 1'b0;
    enable_i = 1'b0;
    step();

    // ---- T5: enable 1->0->1 with 2 samples buffered
    push_word(16'h50);
    push_word(16'h51);
    rate_div_i = 16'd3;
    enable_i   = 1'b1;
    step();
    step();
    check("t5_clr_first", 32'(avg_clr_o), 32'd1);
    step();
    enable_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | dout_update_o | underrun_o | avg_clr_o;
    end
    check("t5_idle_silent", 32'(seen), 32'd0);
    check("t5_fill_kept", 32'(fill_o), 32'd2);
    enable_i = 1'b1;
    step();
    step();
    check("t5_clr_again", 32'(avg_clr_o), 32'd1);
    quiet("t5_gap0", 2);
    step();
    expect_strobe("t5_s0", 16'h50);
    quiet("t5_gap1", 2);
    step();
    expect_strobe("t5_s1", 16'h51);
    check("t5_fill_empty", 32'(fill_o), 32'd0);
    quiet("t5_gap2", 2);
    step();
    expect_underrun("t5_under", 16'h51);
    enable_i = 1'b0;
    step();

    // ---- T6: asynchronous reset mid-run with fill 4
    for (int i = 0; i < 4; i++) push_word(16'h60 + 16'(i));
    rate_div_i = 16'd10;
    enable_i   = 1'b1;
    step();
    step();
    step();
    check("t6_fill4", 32'(fill_o), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_dout",  32'(dout_o), 32'd0);
    check("t6_rst_upd",   32'(dout_update_o), 32'd0);
    check("t6_rst_clr",   32'(avg_clr_o), 32'd0);
    check("t6_rst_und",   32'(underrun_o), 32'd0);
    check("t6_rst_fill",  32'(fill_o), 32'd0);
    check("t6_rst_ready", 32'(s_ready_o), 32'd1);
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | dout_update_o | underrun_o | avg_clr_o;
    end
    check("t6_post_rst_quiet", 32'(seen), 32'd0);
    rate_div_i = 16'd1;
    enable_i   = 1'b1;
    step();
    step();
    check("t6_clr_on_enable", 32'(avg_clr_o), 32'd1);
    step();
    expect_underrun("t6_contents_lost", 16'd0);
    enable_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ste_sample_pacer.md
Name: ste_sample_pacer

Overview:
- Producer side of the STE sample interface: drives dout_o/dout_update_o/avg_clr_o into the downstream averager's din_i/din_update_i/avg_clr_i.
- Accepts samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per programmable tick period as a single-cycle update strobe.
- Issues a one-cycle average clear at every start of a run so the downstream averager begins from a known state.

Parameters:
- DATA_W, 16, sample width
- DEPTH, 8, FIFO depth in samples; power of 2, at least 2
- DIV_W, 16, width of the rate divider

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- s_data_i  input  DATA_W  upstream sample
- s_valid_i  input  1  upstream sample valid
- s_ready_o  output  1  FIFO can accept; equals not-full
- enable_i  input  1  run request (level)
- rate_div_i  input  DIV_W  tick period in clk cycles; 0 is treated as 1
- flush_i  input  1  discard FIFO contents
- dout_o  output  DATA_W  sample to downstream averager
- dout_update_o  output  1  one-cycle strobe, dout_o valid
- avg_clr_o  output  1  one-cycle clear pulse to downstream averager
- fill_o  output  $clog2(DEPTH)+1  current FIFO occupancy
- underrun_o  output  1  one-cycle pulse: tick with empty FIFO

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values:
  - dout_o=0, dout_update_o=0, avg_clr_o=0, underrun_o=0.
  - FIFO empty, fill_o=0, s_ready_o=1.
  - FSM in IDLE, tick counter=0.
- Push: occurs when s_valid_i && s_ready_o && !flush_i. s_ready_o is combinational from occupancy (fill_o<DEPTH).
- FIFO storage:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - No bypass: a sample pushed in cycle N is poppable at the earliest in cycle N+1.
- Simultaneous push and pop is allowed; fill_o is unchanged in that case.
- FSM states:
  - IDLE: outputs quiet. enable_i=1 -> CLEAR.
  - CLEAR: lasts exactly one cycle. avg_clr_o=1 in the following cycle (registered). Counter loaded with max(rate_div_i,1)-1. -> RUN.
  - RUN:
    - Tick when counter==0; on a tick, reload the counter with max(rate_div_i,1)-1, otherwise decrement.
    - rate_div_i is sampled only on load/reload.
    - enable_i=0 -> IDLE in the next cycle; no tick is processed in that cycle.
- Tick handling (RUN, tick cycle):
  - FIFO not empty: pop; dout_o<=head; dout_update_o<=1 next cycle.
  - FIFO empty: underrun_o<=1 next cycle; dout_o holds; no update strobe.
- dout_update_o and underrun_o are never both high. Outside tick response cycles both are 0.
- dout_o holds its last value between strobes and across IDLE.
- Disabling does not clear the FIFO. Re-enabling always passes through CLEAR, so avg_clr_o pulses on every run start.
- Output latency: first strobe occurs max(rate_div_i,1) cycles after the avg_clr_o pulse.
- flush_i:
  - Pointers and fill reset at the clock edge where flush_i=1.
  - Overrides a same-cycle push and pop: the push is dropped, and the tick still occurs but is treated as an empty FIFO (underrun).
  - FSM state and counter are unaffected.
- Full: s_ready_o=0, so upstream must hold the sample; a same-cycle pop frees a slot only for the following cycle.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents are lost, and no avg_clr_o is generated by reset itself.

Optional Feature:
- Macro: STE_PACER_HOLD_LAST_EN.
- Defined: a tick with an empty FIFO re-emits the last dout_o with dout_update_o=1 (a zero-order hold, so the downstream averager keeps its rate), and underrun_o still pulses in the same cycle.
- Not defined: an underrun produces no update strobe, as described in Behaviour.

Test Plan:
- Reset, then push 3,5,7; enable_i=1 with rate_div_i=4 -> avg_clr_o pulses once. Strobes follow at 4-cycle spacing with dout_o=3,5,7. The 4th tick gives an underrun_o pulse and no strobe (hold-last build: strobe with 7 plus underrun_o).
- rate_div_i=0 with FIFO preloaded with 8 samples -> strobes on 8 consecutive cycles, in order, then underrun.
- Push 9 samples with enable_i=0 -> s_ready_o drops after 8, fill_o=8, and the 9th is held upstream. Enable with rate_div_i=2 -> the 9th is accepted the cycle after the first pop; order preserved across pointer wrap.
- flush_i asserted with fill_o=5 while s_valid_i=1 on the same cycle -> fill_o=0 next cycle and the pushed sample is discarded. The next tick gives an underrun.
- Toggle enable_i 1->0->1 mid-run with 2 samples buffered -> no strobe while IDLE, a second avg_clr_o pulse on re-enable, and the buffered samples are emitted after max(rate_div_i,1) cycles.
- Assert rst_n=0 mid-RUN with fill_o=4 -> all outputs go to 0 asynchronously, fill_o=0 and s_ready_o=1; no strobe and no clear after release until enable_i is asserted.
